// File: rtl/imem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
package imem_pkg;

    // Controller states: serve fetches, accept program bytes, announce end of load.
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } imem_state_t;

    // Word handed back on a faulting fetch and seen on fetch_instr out of reset.
    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

    // A fetch faults when the byte address is not word aligned or points past the array.
    function automatic logic is_fetch_fault(input logic [31:0] addr, input int unsigned addr_width);
        logic [31:0] upper;
        if (addr_width + 2 >= 32) begin
            upper = 32'd0;
        end else begin
            upper = addr >> (addr_width + 2);
        end
        return (addr[1:0] != 2'b00) || (upper != 32'd0);
    endfunction

endpackage

// File: rtl/imem_byte_assembler.sv
// Collects a big-endian byte stream into instruction words.
// word_valid is combinational and marks the cycle carrying the last byte of a word,
// so the owner can write the finished word in that same cycle.
module imem_byte_assembler
    import imem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_in,
    output logic                  word_valid,
    output logic [DATA_WIDTH-1:0] word
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

    logic [CNT_W-1:0] count_q;

    assign word_valid = byte_valid && !clear && (count_q == LAST_BYTE);

    // Byte position within the word being assembled; clear discards any partial word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (byte_valid) begin
            if (word_valid) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    if (DATA_WIDTH > 8) begin : g_wide
        logic [DATA_WIDTH-9:0] shift_q;

        assign word = {shift_q, byte_in};

        // Earlier bytes of the word shift up so the first byte ends in the MSB.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                shift_q <= '0;
            end else if (byte_valid && !clear) begin
                shift_q <= word[DATA_WIDTH-9:0];
            end
        end
    end else begin : g_narrow
        assign word = byte_in;
    end

endmodule

// File: rtl/imem_loadable.sv
// Instruction memory with a one-cycle synchronous fetch port and a byte-stream
// program-load port driven by the UART bootloader. Faulting fetches are flagged
// and answered with NOP_WORD instead of reading the array.
module imem_loadable
    import imem_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(DEFAULT_NOP_WORD),
    parameter string                 INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fetch_req,
    input  logic [31:0]           fetch_addr,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_instr,
    output logic                  fetch_fault,
    input  logic                  load_en,
    input  logic                  load_byte_valid,
    input  logic [7:0]            load_byte,
    output logic                  load_busy,
    output logic                  load_done,
    output logic [ADDR_WIDTH:0]   load_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = {ADDR_WIDTH{1'b1}};

    imem_state_t state_q;
    imem_state_t state_d;

    logic                  armed_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH:0]   count_q;

    logic                  start_load;
    logic                  accept_byte;
    logic                  asm_clear;
    logic                  word_valid;
    logic [DATA_WIDTH-1:0] word;
    logic                  mem_full;

    logic                  busy;
    logic                  done;
    logic                  fetch_open;

    logic                  fetch_take;
    logic                  fault_now;
    logic                  read_en;
    logic [ADDR_WIDTH-1:0] fetch_idx;

    logic                  valid_q;
    logic                  fault_q;
    logic                  nop_sel_q;
    logic [DATA_WIDTH-1:0] rd_data;

    // The array starts zeroed; the program image normally arrives through the load port.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    // A load starts only from RUN, and only once load_en has been seen low since the last load.
    assign start_load  = (state_q == ST_RUN) && load_en && armed_q;
    assign accept_byte = (state_q == ST_LOAD) && load_en && load_byte_valid;
    assign asm_clear   = (state_q != ST_LOAD);
    assign mem_full    = word_valid && (ptr_q == LAST_INDEX);

    imem_byte_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_assembler (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (asm_clear),
        .byte_valid (accept_byte),
        .byte_in    (load_byte),
        .word_valid (word_valid),
        .word       (word)
    );

    // Controller state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a load ends when load_en drops or the last word of the array is written.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (start_load) state_d = ST_LOAD;
            ST_LOAD: if (!load_en || mem_full) state_d = ST_DONE;
            ST_DONE: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // State decode: the core stalls through LOAD and DONE since fetches are dropped in both.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        fetch_open = 1'b0;
        case (state_q)
            ST_RUN:  fetch_open = 1'b1;
            ST_LOAD: busy = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: fetch_open = 1'b0;
        endcase
    end

    // Re-arm the load trigger whenever load_en is low, disarm when a load starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed_q <= 1'b1;
        end else if (!load_en) begin
            armed_q <= 1'b1;
        end else if (start_load) begin
            armed_q <= 1'b0;
        end
    end

    // Write pointer and completed-word count for the current or most recent load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else if (start_load) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else if (word_valid) begin
            ptr_q   <= ptr_q + ADDR_WIDTH'(1);
            count_q <= count_q + (ADDR_WIDTH + 1)'(1);
        end
    end

    // A fetch is served only in RUN and loses to a load starting in the same cycle.
    assign fetch_take = fetch_req && fetch_open && !start_load;
    assign fault_now  = is_fetch_fault(fetch_addr, ADDR_WIDTH);
    assign read_en    = fetch_take && !fault_now;
    assign fetch_idx  = fetch_addr[ADDR_WIDTH+1:2];

    // Single-port block RAM: loader writes and fetch reads never share a cycle.
    always_ff @(posedge clk) begin
        if (word_valid) begin
            mem[ptr_q] <= word;
        end
        if (read_en) begin
            rd_data <= mem[fetch_idx];
        end
    end

    // Fetch response flags; nop_sel remembers whether the last served fetch faulted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            nop_sel_q <= 1'b1;
        end else begin
            valid_q <= fetch_take;
            fault_q <= fetch_take && fault_now;
            if (fetch_take) begin
                nop_sel_q <= fault_now;
            end
        end
    end

    assign fetch_valid = valid_q;
    assign fetch_fault = fault_q;
    assign fetch_instr = nop_sel_q ? NOP_WORD : rd_data;
    assign load_busy   = busy;
    assign load_done   = done;
    assign load_count  = count_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed self-checking bench for imem_loadable with the default 256-word, 32-bit geometry.
module tb_imem_loadable;

    logic        clk;
    logic        reset_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_fault;
    logic        load_en;
    logic        load_byte_valid;
    logic [7:0]  load_byte;
    logic        load_busy;
    logic        load_done;
    logic [8:0]  load_count;

    int checks;
    int fails;

    imem_loadable #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .fetch_req       (fetch_req),
        .fetch_addr      (fetch_addr),
        .fetch_valid     (fetch_valid),
        .fetch_instr     (fetch_instr),
        .fetch_fault     (fetch_fault),
        .load_en         (load_en),
        .load_byte_valid (load_byte_valid),
        .load_byte       (load_byte),
        .load_busy       (load_busy),
        .load_done       (load_done),
        .load_count      (load_count)
    );

    // Free-running 10 ns core clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one program byte for one cycle.
    task automatic send_byte(input logic [7:0] b);
        load_byte_valid = 1'b1;
        load_byte       = b;
        tick();
        load_byte_valid = 1'b0;
    endtask

    // Issue one fetch request; the response is visible on return.
    task automatic do_fetch(input logic [31:0] addr);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        tick();
        fetch_req  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        checks++; if (fetch_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %0b want 0", fetch_valid); end
        checks++; if (fetch_instr !== 32'h0) begin fails++; $display("[TB] FAIL reset_instr: got %08h want 00000000", fetch_instr); end
        checks++; if (fetch_fault !== 1'b0) begin fails++; $display("[TB] FAIL reset_fault: got %0b want 0", fetch_fault); end
        checks++; if (load_busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %0b want 0", load_busy); end
        checks++; if (load_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %0b want 0", load_done); end
        checks++; if (load_count !== 9'd0) begin fails++; $display("[TB] FAIL reset_count: got %0d want 0", load_count); end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_load_basic();
        load_en = 1'b1;
        tick();
        checks++; if (load_busy !== 1'b1) begin fails++; $display("[TB] FAIL basic_busy: got %0b want 1", load_busy); end
        send_byte(8'h08); send_byte(8'h00); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h20); send_byte(8'h1c); send_byte(8'h00); send_byte(8'h00);
        checks++; if (load_done !== 1'b0) begin fails++; $display("[TB] FAIL basic_early_done: got %0b want 0", load_done); end
        load_en = 1'b0;
        tick();
        checks++; if (load_done !== 1'b1) begin fails++; $display("[TB] FAIL basic_done: got %0b want 1", load_done); end
        checks++; if (load_count !== 9'd2) begin fails++; $display("[TB] FAIL basic_count: got %0d want 2", load_count); end
        tick();
        checks++; if (load_done !== 1'b0) begin fails++; $display("[TB] FAIL basic_done_pulse: got %0b want 0", load_done); end
        checks++; if (load_busy !== 1'b0) begin fails++; $display("[TB] FAIL basic_busy_end: got %0b want 0", load_busy); end
        do_fetch(32'h0);
        checks++; if (fetch_valid !== 1'b1) begin fails++; $display("[TB] FAIL basic_valid0: got %0b want 1", fetch_valid); end
        checks++; if (fetch_instr !== 32'h08000003) begin fails++; $display("[TB] FAIL basic_word0: got %08h want 08000003", fetch_instr); end
        checks++; if (fetch_fault !== 1'b0) begin fails++; $display("[TB] FAIL basic_fault0: got %0b want 0", fetch_fault); end
        do_fetch(32'h4);
        checks++; if (fetch_instr !== 32'h201c0000) begin fails++; $display("[TB] FAIL basic_word1: got %08h want 201c0000", fetch_instr); end
        tick();
        checks++; if (fetch_valid !== 1'b0) begin fails++; $display("[TB] FAIL idle_valid: got %0b want 0", fetch_valid); end
        checks++; if (fetch_instr !== 32'h201c0000) begin fails++; $display("[TB] FAIL idle_hold: got %08h want 201c0000", fetch_instr); end
    endtask

    task automatic test_fault();
        do_fetch(32'h6);
        checks++; if (fetch_valid !== 1'b1) begin fails++; $display("[TB] FAIL misalign_valid: got %0b want 1", fetch_valid); end
        checks++; if (fetch_fault !== 1'b1) begin fails++; $display("[TB] FAIL misalign_fault: got %0b want 1", fetch_fault); end
        checks++; if (fetch_instr !== 32'h0) begin fails++; $display("[TB] FAIL misalign_instr: got %08h want 00000000", fetch_instr); end
        do_fetch(32'h4);
        checks++; if (fetch_fault !== 1'b0) begin fails++; $display("[TB] FAIL fault_clear: got %0b want 0", fetch_fault); end
        do_fetch(32'h400);
        checks++; if (fetch_valid !== 1'b1) begin fails++; $display("[TB] FAIL range_valid: got %0b want 1", fetch_valid); end
        checks++; if (fetch_fault !== 1'b1) begin fails++; $display("[TB] FAIL range_fault: got %0b want 1", fetch_fault); end
        checks++; if (fetch_instr !== 32'h0) begin fails++; $display("[TB] FAIL range_instr: got %08h want 00000000", fetch_instr); end
        do_fetch(32'h8000_0000);
        checks++; if (fetch_fault !== 1'b1) begin fails++; $display("[TB] FAIL high_fault: got %0b want 1", fetch_fault); end
        do_fetch(32'h3FC);
        checks++; if (fetch_fault !== 1'b0) begin fails++; $display("[TB] FAIL top_word_fault: got %0b want 0", fetch_fault); end
    endtask

    task automatic test_partial();
        load_en = 1'b1;
        tick();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
        load_en = 1'b0;
        tick();
        checks++; if (load_done !== 1'b1) begin fails++; $display("[TB] FAIL partial_done: got %0b want 1", load_done); end
        checks++; if (load_count !== 9'd1) begin fails++; $display("[TB] FAIL partial_count: got %0d want 1", load_count); end
        tick();
        do_fetch(32'h0);
        checks++; if (fetch_instr !== 32'h11223344) begin fails++; $display("[TB] FAIL partial_word0: got %08h want 11223344", fetch_instr); end
        do_fetch(32'h4);
        checks++; if (fetch_instr !== 32'h201c0000) begin fails++; $display("[TB] FAIL partial_word1_kept: got %08h want 201c0000", fetch_instr); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [4];
        seq[0] = 8'hAA; seq[1] = 8'hBB; seq[2] = 8'hCC; seq[3] = 8'hDD;
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        tick();
        checks++; if (fetch_valid !== 1'b1) begin fails++; $display("[TB] FAIL b2b_pre_valid: got %0b want 1", fetch_valid); end
        checks++; if (fetch_instr !== 32'h11223344) begin fails++; $display("[TB] FAIL b2b_pre_instr: got %08h want 11223344", fetch_instr); end
        load_en = 1'b1;
        tick();
        checks++; if (fetch_valid !== 1'b0) begin fails++; $display("[TB] FAIL b2b_load_wins: got %0b want 0", fetch_valid); end
        checks++; if (load_busy !== 1'b1) begin fails++; $display("[TB] FAIL b2b_busy: got %0b want 1", load_busy); end
        for (int i = 0; i < 4; i++) begin
            send_byte(seq[i]);
            checks++; if (fetch_valid !== 1'b0) begin fails++; $display("[TB] FAIL b2b_load_valid%0d: got %0b want 0", i, fetch_valid); end
        end
        load_en = 1'b0;
        tick();
        checks++; if (load_done !== 1'b1) begin fails++; $display("[TB] FAIL b2b_done: got %0b want 1", load_done); end
        checks++; if (fetch_valid !== 1'b0) begin fails++; $display("[TB] FAIL b2b_at_done_valid: got %0b want 0", fetch_valid); end
        checks++; if (load_busy !== 1'b1) begin fails++; $display("[TB] FAIL b2b_done_busy: got %0b want 1", load_busy); end
        tick();
        checks++; if (fetch_valid !== 1'b0) begin fails++; $display("[TB] FAIL b2b_after_done_valid: got %0b want 0", fetch_valid); end
        tick();
        checks++; if (fetch_valid !== 1'b1) begin fails++; $display("[TB] FAIL b2b_resume_valid: got %0b want 1", fetch_valid); end
        checks++; if (fetch_instr !== 32'hAABBCCDD) begin fails++; $display("[TB] FAIL b2b_resume_instr: got %08h want aabbccdd", fetch_instr); end
        fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_load();
        int done_seen;
        done_seen = 0;
        load_en = 1'b1;
        tick();
        send_byte(8'h01);
        send_byte(8'h02);
        reset_n = 1'b0;
        #2;
        checks++; if (load_busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_mid_busy: got %0b want 0", load_busy); end
        checks++; if (load_count !== 9'd0) begin fails++; $display("[TB] FAIL rst_mid_count: got %0d want 0", load_count); end
        load_en = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (load_done === 1'b1) done_seen++;
        end
        checks++; if (done_seen !== 0) begin fails++; $display("[TB] FAIL rst_mid_no_done: got %0d pulses want 0", done_seen); end
        checks++; if (load_busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_mid_busy_after: got %0b want 0", load_busy); end
        do_fetch(32'h0);
        checks++; if (fetch_instr !== 32'hAABBCCDD) begin fails++; $display("[TB] FAIL rst_mid_word0: got %08h want aabbccdd", fetch_instr); end
    endtask

    task automatic test_full();
        int         done_hits;
        int         done_at;
        logic [8:0] count_at_done;
        logic [7:0] b;
        done_hits     = 0;
        done_at       = -1;
        count_at_done = '0;
        load_en = 1'b1;
        tick();
        for (int i = 0; i < 1030; i++) begin
            b = (i < 1024) ? 8'(i) : 8'hEE;
            send_byte(b);
            if (load_done === 1'b1) begin
                done_hits++;
                done_at       = i;
                count_at_done = load_count;
            end
        end
        checks++; if (done_hits !== 1) begin fails++; $display("[TB] FAIL full_done_hits: got %0d want 1", done_hits); end
        checks++; if (done_at !== 1023) begin fails++; $display("[TB] FAIL full_done_at: got byte %0d want 1023", done_at); end
        checks++; if (count_at_done !== 9'd256) begin fails++; $display("[TB] FAIL full_count_at_done: got %0d want 256", count_at_done); end
        checks++; if (load_count !== 9'd256) begin fails++; $display("[TB] FAIL full_count_after: got %0d want 256", load_count); end
        checks++; if (load_busy !== 1'b0) begin fails++; $display("[TB] FAIL full_no_reload: got %0b want 0", load_busy); end
        load_en = 1'b0;
        tick();
        tick();
        do_fetch(32'h3FC);
        checks++; if (fetch_instr !== 32'hFCFDFEFF) begin fails++; $display("[TB] FAIL full_last_word: got %08h want fcfdfeff", fetch_instr); end
        checks++; if (fetch_fault !== 1'b0) begin fails++; $display("[TB] FAIL full_last_fault: got %0b want 0", fetch_fault); end
        do_fetch(32'h3F8);
        checks++; if (fetch_instr !== 32'hF8F9FAFB) begin fails++; $display("[TB] FAIL full_word254: got %08h want f8f9fafb", fetch_instr); end
        do_fetch(32'h0);
        checks++; if (fetch_instr !== 32'h00010203) begin fails++; $display("[TB] FAIL full_word0_untouched: got %08h want 00010203", fetch_instr); end
        do_fetch(32'h4);
        checks++; if (fetch_instr !== 32'h04050607) begin fails++; $display("[TB] FAIL full_word1: got %08h want 04050607", fetch_instr); end
    endtask

    // Scenario sequence; later scenarios rely on memory contents left by earlier ones.
    initial begin
        checks          = 0;
        fails           = 0;
        reset_n         = 1'b1;
        fetch_req       = 1'b0;
        fetch_addr      = 32'h0;
        load_en         = 1'b0;
        load_byte_valid = 1'b0;
        load_byte       = 8'h00;
        #2;
        test_reset();
        test_load_basic();
        test_fault();
        test_partial();
        test_back_to_back();
        test_reset_mid_load();
        test_full();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
